// File: rtl/acia_host_if.sv
// ACIA-style register bus (chip select, write enable, register select, 8-bit data, irq).
// The host drives the strobes as master; the ACIA register block answers as slave.
interface acia_host_if;
   logic       cs;
   logic       we;
   logic       rs;
   logic [7:0] dout;
   logic [7:0] din;
   logic       irq;

   modport master (output cs, we, rs, dout, input din, irq);
   modport slave  (input cs, we, rs, dout, output din, irq);
endinterface

// File: rtl/acia_host.sv
// acia_host: CPU-style initiator that initialises an ACIA, polls status and bridges RX/TX bytes to streams.
// Optional macro ACIA_HOST_IRQ_EN: RX irq forced on in the config byte and polls gated by irq/tx demand.
module acia_host #(
   parameter logic [7:0]  CTRL_INIT = 8'h15,
   parameter int unsigned POLL_DIV  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   acia_host_if.master bus,
   input  logic [7:0]  s_tx_data,
   input  logic        s_tx_val,
   output logic        s_tx_rdy,
   output logic [7:0]  m_rx_data,
   output logic        m_rx_val,
   input  logic        m_rx_rdy
);

   localparam int unsigned     CNT_W   = (POLL_DIV > 0) ? $clog2(POLL_DIV + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(POLL_DIV);

`ifdef ACIA_HOST_IRQ_EN
   localparam logic [7:0] CFG_BYTE = CTRL_INIT | 8'h80;
`else
   localparam logic [7:0] CFG_BYTE = CTRL_INIT;
`endif

   typedef enum logic [3:0] {
      RST_WR, CFG_WR, IDLE, POLL, STAT, RD, RDCAP, WR, GAP
   } state_t;

   state_t           state_q, state_d;
   state_t           gap_next_q, gap_next_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cs_q, cs_d;
   logic             we_q, we_d;
   logic             rs_q, rs_d;
   logic [7:0]       dout_q, dout_d;
   logic             s_tx_rdy_q, s_tx_rdy_d;
   logic [7:0]       m_rx_data_q, m_rx_data_d;
   logic             m_rx_val_q, m_rx_val_d;
   logic             prio_tx_q, prio_tx_d;

   logic rx_go;
   logic tx_go;
   logic wake;

   assign rx_go = bus.din[0] & ~m_rx_val_q;
   assign tx_go = bus.din[1] & s_tx_val;

`ifdef ACIA_HOST_IRQ_EN
   assign wake = (bus.irq & ~m_rx_val_q) | s_tx_val;
`else
   logic unused_irq;
   assign unused_irq = bus.irq;
   assign wake       = 1'b1;
`endif

   // Strobes are set on the transition into the cycle where they appear on the bus.
   always_comb begin
      state_d     = state_q;
      gap_next_d  = gap_next_q;
      cnt_d       = '0;
      cs_d        = 1'b0;
      we_d        = 1'b0;
      rs_d        = 1'b0;
      dout_d      = dout_q;
      s_tx_rdy_d  = 1'b0;
      m_rx_data_d = m_rx_data_q;
      m_rx_val_d  = m_rx_val_q & ~m_rx_rdy;
      prio_tx_d   = prio_tx_q;

      unique case (state_q)
         RST_WR: begin
            cs_d       = 1'b1;
            we_d       = 1'b1;
            dout_d     = 8'h03;
            gap_next_d = CFG_WR;
            state_d    = GAP;
         end
         CFG_WR: begin
            cs_d       = 1'b1;
            we_d       = 1'b1;
            dout_d     = CFG_BYTE;
            gap_next_d = IDLE;
            state_d    = GAP;
         end
         IDLE: begin
            cnt_d = (cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
            if ((cnt_q == CNT_MAX) && wake) begin
               cnt_d   = '0;
               cs_d    = 1'b1;
               state_d = POLL;
            end
         end
         POLL: state_d = STAT;
         // Status is valid now; RX wins a tie only when it is RX's turn.
         STAT: begin
            if (rx_go && (!tx_go || !prio_tx_q)) begin
               cs_d    = 1'b1;
               rs_d    = 1'b1;
               state_d = RD;
            end else if (tx_go) begin
               state_d = WR;
            end else begin
               state_d = IDLE;
            end
         end
         RD: state_d = RDCAP;
         RDCAP: begin
            m_rx_data_d = bus.din;
            m_rx_val_d  = 1'b1;
            prio_tx_d   = 1'b1;
            state_d     = IDLE;
         end
         WR: begin
            if (s_tx_val) begin
               cs_d       = 1'b1;
               we_d       = 1'b1;
               rs_d       = 1'b1;
               dout_d     = s_tx_data;
               s_tx_rdy_d = 1'b1;
               prio_tx_d  = 1'b0;
               gap_next_d = IDLE;
               state_d    = GAP;
            end else begin
               state_d = IDLE;
            end
         end
         GAP:     state_d = gap_next_q;
         default: state_d = RST_WR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= RST_WR;
         gap_next_q  <= RST_WR;
         cnt_q       <= '0;
         cs_q        <= 1'b0;
         we_q        <= 1'b0;
         rs_q        <= 1'b0;
         dout_q      <= 8'h00;
         s_tx_rdy_q  <= 1'b0;
         m_rx_data_q <= 8'h00;
         m_rx_val_q  <= 1'b0;
         prio_tx_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         gap_next_q  <= gap_next_d;
         cnt_q       <= cnt_d;
         cs_q        <= cs_d;
         we_q        <= we_d;
         rs_q        <= rs_d;
         dout_q      <= dout_d;
         s_tx_rdy_q  <= s_tx_rdy_d;
         m_rx_data_q <= m_rx_data_d;
         m_rx_val_q  <= m_rx_val_d;
         prio_tx_q   <= prio_tx_d;
      end
   end

   assign bus.cs    = cs_q;
   assign bus.we    = we_q;
   assign bus.rs    = rs_q;
   assign bus.dout  = dout_q;
   assign s_tx_rdy  = s_tx_rdy_q;
   assign m_rx_data = m_rx_data_q;
   assign m_rx_val  = m_rx_val_q;

endmodule

// File: tb/tb_acia_host.sv
// Testbench for acia_host: small ACIA register model plus write/RX scoreboards and protocol monitors.
module tb_acia_host;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] s_tx_data = 8'h00;
   logic       s_tx_val = 1'b0;
   logic       s_tx_rdy;
   logic [7:0] m_rx_data;
   logic       m_rx_val;
   logic       m_rx_rdy = 1'b0;

   acia_host_if bus ();

   acia_host dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .s_tx_data (s_tx_data),
      .s_tx_val  (s_tx_val),
      .s_tx_rdy  (s_tx_rdy),
      .m_rx_data (m_rx_data),
      .m_rx_val  (m_rx_val),
      .m_rx_rdy  (m_rx_rdy)
   );

   always #5 clk = ~clk;

`ifdef ACIA_HOST_IRQ_EN
   localparam logic [7:0] EXP_CFG = 8'h95;
`else
   localparam logic [7:0] EXP_CFG = 8'h15;
`endif

   // ACIA model: status = {tx_empty, rx_full}; a data read hands out the held byte.
   logic       rx_full = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   int         rx_left = 0;
   logic       rx_push = 1'b0;
   logic [7:0] rx_push_byte = 8'h00;
   int         rx_push_cnt = 0;
   logic       tx_empty_in = 1'b1;

   assign bus.irq = rx_full;

   always @(posedge clk) begin
      if (bus.cs && !bus.we) begin
         bus.din <= bus.rs ? rx_byte : {6'b0, tx_empty_in, rx_full};
         if (bus.rs) begin
            if (rx_left != 0) begin
               rx_byte <= rx_byte + 8'd1;
               rx_left <= rx_left - 1;
            end else begin
               rx_full <= 1'b0;
            end
         end
      end
      if (rx_push) begin
         rx_full <= 1'b1;
         rx_byte <= rx_push_byte;
         rx_left <= rx_push_cnt;
      end
   end

   int         n_checks = 0;
   int         n_pass = 0;
   logic [8:0] exp_wr[$];
   logic [7:0] exp_rx[$];
   int         phase = 0;
   logic       prev_cs = 1'b0;
   int         init_cnt = 0;
   int         gap_viol = 0;
   int         early_rs = 0;
   int         coinc_viol = 0;
   int         alt_viol = 0;
   int         p5_acc = 0;
   logic       last_kind = 1'b0;
   bit         have_last = 1'b0;
   int         tx_wr_cnt = 0;
   int         rdy_cnt = 0;
   int         data_rd_cnt = 0;
   int         val_cycles = 0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Load one RX byte (plus extra consecutive bytes) into the ACIA model.
   task automatic applyStimulus(input logic [7:0] b, input int extra);
      @(negedge clk);
      rx_push_byte = b;
      rx_push_cnt  = extra;
      rx_push      = 1'b1;
      @(negedge clk);
      rx_push      = 1'b0;
   endtask

   task automatic txSend(input logic [7:0] b, input bit keep);
      bit got;
      s_tx_data = b;
      s_tx_val  = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         got = s_tx_rdy;
      end
      checkOutput("tx_accept", 32'(got), 32'd1);
      if (!keep) s_tx_val = 1'b0;
   endtask

   task automatic waitDrain(input string tag, input int max_cycles);
      for (int i = 0; i < max_cycles && (exp_wr.size() + exp_rx.size()) != 0; i++)
         @(negedge clk);
      checkOutput(tag, 32'(exp_wr.size() + exp_rx.size()), 32'd0);
   endtask

   task automatic monitorBus();
      logic [8:0] e;
      logic [7:0] r;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.cs && prev_cs) gap_viol++;
            if (bus.cs && bus.rs && init_cnt < 2) early_rs++;
            if (bus.cs && bus.we) begin
               if (!bus.rs) init_cnt = (bus.dout == 8'h03) ? 1 : init_cnt + 1;
               else tx_wr_cnt++;
               if (exp_wr.size() == 0) begin
                  checkOutput("write_unexpected", 32'd1, 32'd0);
               end else begin
                  e = exp_wr.pop_front();
                  checkOutput("write_rs_dout", 32'({bus.rs, bus.dout}), 32'(e));
               end
            end
            if (bus.cs && !bus.we && bus.rs) data_rd_cnt++;
            if (s_tx_rdy) rdy_cnt++;
            if (s_tx_rdy != (bus.cs && bus.we && bus.rs)) coinc_viol++;
            if (phase == 5 && bus.cs && bus.rs) begin
               if (have_last && bus.we == last_kind) alt_viol++;
               last_kind = bus.we;
               have_last = 1'b1;
               p5_acc++;
            end
            if (m_rx_val) val_cycles++;
            if (m_rx_val && m_rx_rdy) begin
               if (exp_rx.size() == 0) begin
                  checkOutput("rx_unexpected", 32'd1, 32'd0);
               end else begin
                  r = exp_rx.pop_front();
                  checkOutput("rx_data", 32'(m_rx_data), 32'(r));
               end
            end
         end
         prev_cs = bus.cs;
      end
   endtask

   initial begin
      int  base_rd, base_wr, base_rdy, base_val;
      bit  seen;

      fork
         monitorBus();
      join_none

      // Reset values and the two-write init sequence.
      phase = 1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_cs", 32'(bus.cs), 32'd0);
      checkOutput("rst_we", 32'(bus.we), 32'd0);
      checkOutput("rst_rs", 32'(bus.rs), 32'd0);
      checkOutput("rst_dout", 32'(bus.dout), 32'd0);
      checkOutput("rst_tx_rdy", 32'(s_tx_rdy), 32'd0);
      checkOutput("rst_rx_val", 32'(m_rx_val), 32'd0);
      checkOutput("rst_rx_data", 32'(m_rx_data), 32'd0);
      exp_wr.push_back({1'b0, 8'h03});
      exp_wr.push_back({1'b0, EXP_CFG});
      rst_n = 1'b1;
      waitDrain("init_writes", 60);

      // Single RX byte with a ready consumer.
      phase = 2;
      m_rx_rdy = 1'b1;
      base_rd  = data_rd_cnt;
      base_val = val_cycles;
      exp_rx.push_back(8'h5A);
      applyStimulus(8'h5A, 0);
      waitDrain("rx_5a", 200);
      repeat (50) @(negedge clk);
      checkOutput("rx_5a_one_read", 32'(data_rd_cnt - base_rd), 32'd1);
      checkOutput("rx_5a_val_cycles", 32'(val_cycles - base_val), 32'd1);

      // Backpressure: held byte blocks further data reads.
      phase = 3;
      m_rx_rdy = 1'b0;
      applyStimulus(8'h11, 0);
      for (int i = 0; i < 200 && !m_rx_val; i++) @(negedge clk);
      checkOutput("rx_held_valid", 32'(m_rx_val), 32'd1);
      checkOutput("rx_held_data", 32'(m_rx_data), 32'h11);
      base_rd = data_rd_cnt;
      applyStimulus(8'h22, 0);
      repeat (60) @(negedge clk);
      checkOutput("no_read_while_full", 32'(data_rd_cnt - base_rd), 32'd0);
      checkOutput("rx_still_held", 32'(m_rx_val), 32'd1);
      exp_rx.push_back(8'h11);
      exp_rx.push_back(8'h22);
      m_rx_rdy = 1'b1;
      waitDrain("rx_11_22", 200);

      // TX write, then TX blocked while the ACIA reports not-empty.
      phase = 4;
      base_wr  = tx_wr_cnt;
      base_rdy = rdy_cnt;
      exp_wr.push_back({1'b1, 8'hA5});
      txSend(8'hA5, 1'b0);
      repeat (40) @(negedge clk);
      checkOutput("tx_a5_one_write", 32'(tx_wr_cnt - base_wr), 32'd1);
      checkOutput("tx_a5_one_rdy", 32'(rdy_cnt - base_rdy), 32'd1);
      base_wr  = tx_wr_cnt;
      base_rdy = rdy_cnt;
      tx_empty_in = 1'b0;
      s_tx_data   = 8'h3C;
      s_tx_val    = 1'b1;
      repeat (60) @(negedge clk);
      checkOutput("tx_busy_no_write", 32'(tx_wr_cnt - base_wr), 32'd0);
      checkOutput("tx_busy_no_rdy", 32'(rdy_cnt - base_rdy), 32'd0);
      exp_wr.push_back({1'b1, 8'h3C});
      tx_empty_in = 1'b1;
      txSend(8'h3C, 1'b0);
      waitDrain("tx_3c", 60);

      // RX and TX both pending: data accesses must alternate.
      phase = 5;
      for (int i = 0; i < 6; i++) exp_rx.push_back(8'h80 + 8'(i));
      applyStimulus(8'h80, 5);
      for (int i = 0; i < 6; i++) begin
         exp_wr.push_back({1'b1, 8'h40 + 8'(i)});
         txSend(8'h40 + 8'(i), 1'b1);
      end
      s_tx_val = 1'b0;
      waitDrain("both_pending", 300);
      checkOutput("alt_violations", 32'(alt_viol), 32'd0);
      checkOutput("alt_access_count", 32'(p5_acc), 32'd12);

      // Reset pulse landing on the RX capture cycle.
      phase = 6;
      applyStimulus(8'h77, 0);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         seen = bus.cs && !bus.we && bus.rs;
      end
      checkOutput("rd_strobe_seen", 32'(seen), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midrst_rx_val", 32'(m_rx_val), 32'd0);
      checkOutput("midrst_cs", 32'(bus.cs), 32'd0);
      exp_wr.push_back({1'b0, 8'h03});
      exp_wr.push_back({1'b0, EXP_CFG});
      rst_n = 1'b1;
      waitDrain("reinit_writes", 60);
      repeat (40) @(negedge clk);

      checkOutput("cs_back_to_back", 32'(gap_viol), 32'd0);
      checkOutput("rs1_before_init", 32'(early_rs), 32'd0);
      checkOutput("tx_rdy_coincidence", 32'(coinc_viol), 32'd0);
      checkOutput("leftover_expected", 32'(exp_wr.size() + exp_rx.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
